window_3x3_gen: RTL
===================

// Module: window_3x3_gen
// PURPOSE
//  Upstream feeder for the 3x3 weighted-sum (mean) stage.
//  - Accepts a raster-order stream of binary pixels, one per accepted cycle.
//  - Holds the two previous image rows in line buffers.
//  - Presents each complete 3x3 neighbourhood as nine single-bit outputs X_0..X_8
//    with a valid strobe; these drive the weighted-sum stage's pixel inputs directly.
// PARAMETERS
//  IMG_W  28  pixels per row (>=3)
//  IMG_H  28  rows per frame (>=3)
// PORTS
//  clk         in   1                rising-edge clock, single clock domain
//  rst_n       in   1                asynchronous active-low reset
//  sof         in   1                start of frame; resynchronises counters
//  pix_in      in   1                binary pixel, 0 or 1
//  pix_valid   in   1                pix_in is accepted this cycle
//  X_0..X_8    out  1 each           window; row-major order
//                                    - X_0 = top-left, X_2 = top-right
//                                    - X_6 = bottom-left, X_8 = bottom-right (newest pixel)
//  win_valid   out  1                X_0..X_8 form a full in-image window (1-cycle pulse)
//  win_row     out  $clog2(IMG_H)    window centre row, (row of newest pixel) - 1
//  win_col     out  $clog2(IMG_W)    window centre column, (col of newest pixel) - 1
//  frame_done  out  1                pulses with the window that completes the frame
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - All outputs 0.
//    - Row/col counters 0.
//    - Both line buffers and window registers cleared to 0.
//  - Accept: pixel accepted on a cycle where pix_valid=1. With pix_valid=0, all state holds
//    and win_valid/frame_done drop to 0.
//  - Line buffers: two IMG_W-bit shift registers, advanced only on accept.
//    - lb1 delays pix_in by IMG_W accepts (row r-1).
//    - lb2 delays lb1's output by IMG_W accepts (row r-2).
//  - Window shift, on each accept:
//    - Columns shift left: X_0<=X_1, X_1<=X_2, X_3<=X_4, ...
//    - New right column: X_2<=lb2_out, X_5<=lb1_out, X_8<=pix_in.
//  - Counters:
//    - col increments per accept.
//    - At col=IMG_W-1: col->0 and row increments.
//    - At (IMG_H-1, IMG_W-1): row and col both -> 0.
//  - win_valid:
//    - Registered.
//    - Asserted the cycle after an accept whose pre-increment (row,col) has row>=2 and col>=2.
//    - Latency: 1 cycle from the completing pixel to its window.
//    - No edge padding; windows at col 0/1 contain stale columns and are never flagged valid.
//  - Window count: exactly (IMG_W-2)*(IMG_H-2) valid windows per frame.
//  - win_row/win_col: registered alongside win_valid; hold their last value when win_valid=0.
//  - frame_done: asserted with the window from pixel (IMG_H-1, IMG_W-1).
//  - sof:
//    - sof with an accept: that pixel is taken as (0,0); it is counted and written to lb1.
//    - sof without an accept: counters -> 0 and wait for the next accept.
//    - Line buffer contents are not cleared. Stale data is harmless because win_valid
//      is gated by row>=2.
//  - Mid-frame sof aborts the current frame; no frame_done is issued for the aborted frame.
//  - Reset mid-frame: all state lost; the next accept is pixel (0,0) regardless of sof.
//  - No backpressure: the downstream weighted-sum stage is combinational and consumes
//    every window.
// TESTING
//  - Reset, then 28x28 frame of pixel=(col+row)&1, pix_valid=1 continuously ->
//    - Exactly 676 win_valid pulses.
//    - First pulse one cycle after pixel (2,2), with win_row=1, win_col=1 and
//      X_0..X_8 = 0,1,0,1,0,1,0,1,0.
//    - frame_done coincident with the final window (26,26).
//  - Same frame with pix_valid toggling 1,0 ->
//    - Identical window sequence.
//    - win_valid never high two cycles running; outputs hold during gaps.
//  - Single 1 pixel at (5,7), rest 0 ->
//    - Exactly nine windows contain a 1: those centred at rows 4..6, cols 6..8.
//    - Window centred (4,6) shows X_8=1; window centred (6,8) shows X_0=1.
//  - sof asserted at pixel 300 of a frame, then a fresh full frame ->
//    - No frame_done for the aborted frame.
//    - 676 windows from the new frame, first again at (1,1).
//  - rst_n pulsed low mid-frame asynchronously (not clock-aligned) ->
//    - win_valid, frame_done and X_* go to 0 immediately.
//    - After release, a full frame without sof yields 676 correct windows.
//  - IMG_W=3, IMG_H=3 build, 9 pixels all 1 ->
//    - One window, all X_k=1, win_row=win_col=1, frame_done=1.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Purpose : 3x3 sliding-window generator over a raster stream of binary pixels.
// Latency : 1 cycle from the accepted pixel that completes a window to win_valid.
// Backpressure: none; every accepted pixel is consumed and every window is presented once.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (synchronous release upstream)
//   sof               start of frame; the pixel accepted with it is (0,0)
//   pix_in/pix_valid  binary pixel and its accept strobe
//   X_0..X_8          window, row-major; X_0 top-left, X_8 bottom-right (newest pixel)
//   win_valid         X_* hold a complete in-image window (one-cycle pulse)
//   win_row/win_col   centre of the presented window; held while win_valid is low
//   frame_done        pulses with the window completed by the last pixel of the frame
module window_3x3_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sof,
  input  logic          pix_in,
  input  logic          pix_valid,
  output logic          X_0,
  output logic          X_1,
  output logic          X_2,
  output logic          X_3,
  output logic          X_4,
  output logic          X_5,
  output logic          X_6,
  output logic          X_7,
  output logic          X_8,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          frame_done
);

  // Line buffers: bit [0] is the newest entry, bit [IMG_W-1] the one that is
  // exactly one row old and leaves on the next accept.
  logic [IMG_W-1:0] lb1_q, lb1_d;
  logic [IMG_W-1:0] lb2_q, lb2_d;

  // Window register, bit k drives X_k.
  logic [8:0]       win_q, win_d;

  // Position of the next pixel to be accepted.
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;

  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [RW-1:0]    win_row_q, win_row_d;
  logic [CW-1:0]    win_col_q, win_col_d;

  // Position of the pixel on the inputs; sof forces it to (0,0).
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             last_col;
  logic             last_row;
  logic             lb1_out;
  logic             lb2_out;

  always_comb begin
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
    lb1_out  = lb1_q[IMG_W-1];
    lb2_out  = lb2_q[IMG_W-1];
  end

  always_comb begin
    lb1_d        = lb1_q;
    lb2_d        = lb2_q;
    win_d        = win_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;

    if (pix_valid) begin
      lb1_d = {lb1_q[IMG_W-2:0], pix_in};
      lb2_d = {lb2_q[IMG_W-2:0], lb1_out};

      // Columns slide left; the new right column is rows r-2, r-1, r.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_out;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_out;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end

      // Windows touching columns 0/1 or rows 0/1 would mix in stale data
      // from the previous row or frame, so they are never flagged.
      if ((cur_row >= RW'(2)) && (cur_col >= CW'(2))) begin
        win_valid_d  = 1'b1;
        win_row_d    = cur_row - RW'(1);
        win_col_d    = cur_col - CW'(1);
        frame_done_d = last_row && last_col;
      end
    end else if (sof) begin
      // sof on an idle cycle only re-arms the counters.
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb1_q        <= '0;
      lb2_q        <= '0;
      win_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      lb1_q        <= lb1_d;
      lb2_q        <= lb2_d;
      win_q        <= win_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
    end
  end

  assign X_0        = win_q[0];
  assign X_1        = win_q[1];
  assign X_2        = win_q[2];
  assign X_3        = win_q[3];
  assign X_4        = win_q[4];
  assign X_5        = win_q[5];
  assign X_6        = win_q[6];
  assign X_7        = win_q[7];
  assign X_8        = win_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule
